// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request channels (ALU = src 0, MEM = src 1) and the shared register-file write port.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                         alu_valid;
    logic                         alu_ready;
    logic [ADDR_WIDTH-1:0]        alu_rd;
    logic [DATA_WIDTH-1:0]        alu_wd;
    logic                         mem_valid;
    logic                         mem_ready;
    logic [ADDR_WIDTH-1:0]        mem_rd;
    logic [DATA_WIDTH-1:0]        mem_wd;
    logic                         WE3;
    logic [ADDR_WIDTH-1:0]        AD3;
    logic [DATA_WIDTH-1:0]        WD3;
    logic [(1<<ADDR_WIDTH)-1:0]   pending;
    logic                         order_err;

    modport slave (
        input  alu_valid, alu_rd, alu_wd, mem_valid, mem_rd, mem_wd,
        output alu_ready, mem_ready, WE3, AD3, WD3, pending, order_err
    );

    modport master (
        output alu_valid, alu_rd, alu_wd, mem_valid, mem_rd, mem_wd,
        input  alu_ready, mem_ready, WE3, AD3, WD3, pending, order_err
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two per-source writeback FIFOs drained round-robin into a registered register-file write port,
// with a pending-write mask for hazard detection and a sticky cross-source ordering flag.
module regfile_wb_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_arbiter_if.slave wb
);
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned NREG = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] rd_q   [2][DEPTH];
    logic [DATA_WIDTH-1:0] wd_q   [2][DEPTH];
    logic [DEPTH-1:0]      vld    [2];
    logic [PW-1:0]         wr_ptr [2];
    logic [PW-1:0]         rd_ptr [2];
    logic [CW-1:0]         cnt    [2];
    logic                  last;
    logic                  we3;
    logic [ADDR_WIDTH-1:0] ad3;
    logic [DATA_WIDTH-1:0] wd3;
    logic                  err;

    logic                  in_valid [2];
    logic [ADDR_WIDTH-1:0] in_rd    [2];
    logic [DATA_WIDTH-1:0] in_wd    [2];
    logic                  ready    [2];
    logic                  push     [2];
    logic                  ne       [2];
    logic                  grant    [2];
    logic [NREG-1:0]       fmask    [2];
    logic [NREG-1:0]       pend;
    logic                  err_set;

    assign in_valid[0] = wb.alu_valid;
    assign in_rd[0]    = wb.alu_rd;
    assign in_wd[0]    = wb.alu_wd;
    assign in_valid[1] = wb.mem_valid;
    assign in_rd[1]    = wb.mem_rd;
    assign in_wd[1]    = wb.mem_wd;

    // Handshake, x0 filtering and round-robin grant; last=1 means MEM won most recently.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            ready[s] = (cnt[s] != CW'(DEPTH));
            push[s]  = in_valid[s] && ready[s] && (in_rd[s] != '0);
            ne[s]    = (cnt[s] != '0);
        end
        grant[0] = ne[0] && (!ne[1] || last);
        grant[1] = ne[1] && (!ne[0] || !last);
    end

    // Per-source mask of registers with a queued write, plus the combined pending mask.
    always_comb begin
        pend = '0;
        for (int s = 0; s < 2; s++) begin
            fmask[s] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (vld[s][i]) fmask[s][rd_q[s][i]] = 1'b1;
            end
            pend = pend | fmask[s];
        end
        if (we3) pend[ad3] = 1'b1;
    end

    assign err_set = (push[0] && fmask[1][in_rd[0]])
                  || (push[1] && fmask[0][in_rd[1]])
                  || (push[0] && push[1] && (in_rd[0] == in_rd[1]));

    // Payload storage needs no reset: slot validity governs visibility.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                rd_q[s][wr_ptr[s]] <= in_rd[s];
                wd_q[s][wr_ptr[s]] <= in_wd[s];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                vld[s]    <= '0;
                wr_ptr[s] <= '0;
                rd_ptr[s] <= '0;
                cnt[s]    <= '0;
            end
            last <= 1'b1;
            we3  <= 1'b0;
            ad3  <= '0;
            wd3  <= '0;
            err  <= 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (grant[s]) begin
                    vld[s][rd_ptr[s]] <= 1'b0;
                    rd_ptr[s]         <= rd_ptr[s] + PW'(1);
                end
                if (push[s]) begin
                    vld[s][wr_ptr[s]] <= 1'b1;
                    wr_ptr[s]         <= wr_ptr[s] + PW'(1);
                end
                cnt[s] <= cnt[s] + CW'(push[s]) - CW'(grant[s]);
            end
            if (grant[0]) begin
                we3  <= 1'b1;
                ad3  <= rd_q[0][rd_ptr[0]];
                wd3  <= wd_q[0][rd_ptr[0]];
                last <= 1'b0;
            end else if (grant[1]) begin
                we3  <= 1'b1;
                ad3  <= rd_q[1][rd_ptr[1]];
                wd3  <= wd_q[1][rd_ptr[1]];
                last <= 1'b1;
            end else begin
                we3 <= 1'b0;
            end
            if (err_set) err <= 1'b1;
        end
    end

    assign wb.alu_ready = ready[0];
    assign wb.mem_ready = ready[1];
    assign wb.WE3       = we3;
    assign wb.AD3       = ad3;
    assign wb.WD3       = wd3;
    assign wb.pending   = pend;
    assign wb.order_err = err;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_regfile_wb_arbiter;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NREG  = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] wd;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    regfile_wb_arbiter #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    ent_t          aq[$];
    ent_t          mq[$];
    int            m_last;
    logic          m_we;
    logic [AW-1:0] m_ad;
    logic [DW-1:0] m_wd;
    logic          m_err;

    function automatic logic [NREG-1:0] q_mask(input ent_t q[$]);
        logic [NREG-1:0] p = '0;
        foreach (q[i]) p[q[i].rd] = 1'b1;
        return p;
    endfunction

    function automatic logic [NREG-1:0] model_pending();
        logic [NREG-1:0] p = q_mask(aq) | q_mask(mq);
        if (m_we) p[m_ad] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        aq.delete();
        mq.delete();
        m_last = 1;
        m_we   = 1'b0;
        m_ad   = '0;
        m_wd   = '0;
        m_err  = 1'b0;
    endtask

    // One rising edge of the specified behaviour, using the inputs currently on the bus.
    task automatic model_edge();
        bit a_acc, m_acc, a_push, m_push;
        logic [NREG-1:0] amask, mmask;
        int g;
        ent_t e;
        a_acc  = bus.alu_valid && (aq.size() < DEPTH);
        m_acc  = bus.mem_valid && (mq.size() < DEPTH);
        a_push = a_acc && (bus.alu_rd != 0);
        m_push = m_acc && (bus.mem_rd != 0);
        amask  = q_mask(aq);
        mmask  = q_mask(mq);
        if ((a_push && mmask[bus.alu_rd]) || (m_push && amask[bus.mem_rd]) ||
            (a_push && m_push && bus.alu_rd == bus.mem_rd))
            m_err = 1'b1;
        if (aq.size() > 0 && mq.size() > 0) g = 1 - m_last;
        else if (aq.size() > 0)             g = 0;
        else if (mq.size() > 0)             g = 1;
        else                                g = -1;
        if (g == 0)      begin e = aq.pop_front(); end
        else if (g == 1) begin e = mq.pop_front(); end
        if (g >= 0) begin
            m_we = 1'b1; m_ad = e.rd; m_wd = e.wd; m_last = g;
        end else begin
            m_we = 1'b0;
        end
        if (a_push) aq.push_back('{rd: bus.alu_rd, wd: bus.alu_wd});
        if (m_push) mq.push_back('{rd: bus.mem_rd, wd: bus.mem_wd});
    endtask

    task automatic drive(input bit av, input int ard, input logic [DW-1:0] awd,
                         input bit mv, input int mrd, input logic [DW-1:0] mwd);
        bus.alu_valid = av;  bus.alu_rd = AW'(ard); bus.alu_wd = awd;
        bus.mem_valid = mv;  bus.mem_rd = AW'(mrd); bus.mem_wd = mwd;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, '0, 0, 0, '0);
    endtask

    // Advance one clock; the model follows the DUT at the edge, sampling resumes after the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(negedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (2) tick();
        tests++;
        if (bus.WE3 !== 1'b0 || bus.AD3 !== '0 || bus.WD3 !== '0) begin
            fails++; $display("FAIL reset_port: WE3=%b AD3=%0d WD3=%h want 0/0/0", bus.WE3, bus.AD3, bus.WD3);
        end
        tests++;
        if (bus.pending !== '0 || bus.order_err !== 1'b0) begin
            fails++; $display("FAIL reset_flags: pending=%h order_err=%b want 0/0", bus.pending, bus.order_err);
        end
        tests++;
        if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready: alu=%b mem=%b want 1/1", bus.alu_ready, bus.mem_ready);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        drive(1, 5, 32'hDEADBEEF, 0, 0, '0);
        tick();                       // edge N
        idle();
        tests++;
        if (bus.WE3 !== 1'b0 || bus.pending[5] !== 1'b1) begin
            fails++; $display("FAIL single_n: WE3=%b pend5=%b want 0/1", bus.WE3, bus.pending[5]);
        end
        tick();                       // edge N+1
        tests++;
        if (bus.WE3 !== 1'b1 || bus.AD3 !== 5'd5 || bus.WD3 !== 32'hDEADBEEF || bus.pending[5] !== 1'b1) begin
            fails++; $display("FAIL single_wr: WE3=%b AD3=%0d WD3=%h pend5=%b want 1/5/deadbeef/1",
                              bus.WE3, bus.AD3, bus.WD3, bus.pending[5]);
        end
        tick();                       // edge N+2
        tests++;
        if (bus.WE3 !== 1'b0 || bus.pending !== '0 || bus.AD3 !== 5'd5) begin
            fails++; $display("FAIL single_done: WE3=%b pending=%h AD3=%0d want 0/0/5", bus.WE3, bus.pending, bus.AD3);
        end
    endtask

    task automatic test_fill_drain();
        int exp_ad[4] = '{1, 3, 2, 4};
        do_reset();
        drive(1, 1, 32'h11, 1, 3, 32'h33);
        tick();
        drive(1, 2, 32'h22, 1, 4, 32'h44);
        tick();
        idle();
        tests++;
        if (bus.mem_ready !== 1'b0 || bus.alu_ready !== 1'b1) begin
            fails++; $display("FAIL fill_ready: alu=%b mem=%b want 1/0", bus.alu_ready, bus.mem_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (bus.WE3 !== 1'b1 || bus.AD3 !== AW'(exp_ad[i])) begin
                fails++; $display("FAIL drain_seq%0d: WE3=%b AD3=%0d want 1/%0d", i, bus.WE3, bus.AD3, exp_ad[i]);
            end
            tick();
        end
        tests++;
        if (bus.WE3 !== 1'b0 || bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1 || bus.pending !== '0) begin
            fails++; $display("FAIL drain_end: WE3=%b ready=%b%b pending=%h want 0/11/0",
                              bus.WE3, bus.alu_ready, bus.mem_ready, bus.pending);
        end
    endtask

    task automatic test_x0_filter();
        do_reset();
        drive(1, 0, 32'h1234, 1, 0, 32'h1234);
        tests++;
        if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin
            fails++; $display("FAIL x0_ready: alu=%b mem=%b want 1/1", bus.alu_ready, bus.mem_ready);
        end
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (bus.WE3 !== 1'b0 || bus.pending !== '0 || bus.order_err !== 1'b0) begin
                fails++; $display("FAIL x0_cyc%0d: WE3=%b pending=%h err=%b want 0/0/0",
                                  i, bus.WE3, bus.pending, bus.order_err);
            end
            tick();
        end
    endtask

    task automatic test_order_err();
        do_reset();
        drive(1, 7, 32'hA0A0A0A0, 0, 0, '0);
        tick();
        tests++;
        if (bus.order_err !== 1'b0) begin
            fails++; $display("FAIL oerr_clean: order_err=%b want 0", bus.order_err);
        end
        drive(0, 0, '0, 1, 7, 32'hB0B0B0B0);
        tick();
        idle();
        tests++;
        if (bus.order_err !== 1'b1 || bus.WE3 !== 1'b1 || bus.AD3 !== 5'd7 || bus.WD3 !== 32'hA0A0A0A0) begin
            fails++; $display("FAIL oerr_first: err=%b WE3=%b AD3=%0d WD3=%h want 1/1/7/a0a0a0a0",
                              bus.order_err, bus.WE3, bus.AD3, bus.WD3);
        end
        tick();
        tests++;
        if (bus.WE3 !== 1'b1 || bus.AD3 !== 5'd7 || bus.WD3 !== 32'hB0B0B0B0) begin
            fails++; $display("FAIL oerr_second: WE3=%b AD3=%0d WD3=%h want 1/7/b0b0b0b0", bus.WE3, bus.AD3, bus.WD3);
        end
        repeat (3) tick();
        tests++;
        if (bus.order_err !== 1'b1 || bus.WE3 !== 1'b0) begin
            fails++; $display("FAIL oerr_sticky: err=%b WE3=%b want 1/0", bus.order_err, bus.WE3);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1, 1, 32'h1, 1, 2, 32'h2);
        tick();
        drive(1, 3, 32'h3, 1, 4, 32'h4);
        tick();
        idle();
        tests++;
        if (bus.WE3 !== 1'b1 || bus.pending === '0) begin
            fails++; $display("FAIL arst_pre: WE3=%b pending=%h want 1/nonzero", bus.WE3, bus.pending);
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if (bus.WE3 !== 1'b0 || bus.AD3 !== '0 || bus.WD3 !== '0 || bus.pending !== '0 ||
            bus.order_err !== 1'b0 || bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin
            fails++; $display("FAIL arst_now: WE3=%b AD3=%0d WD3=%h pending=%h err=%b ready=%b%b want 0/0/0/0/0/11",
                              bus.WE3, bus.AD3, bus.WD3, bus.pending, bus.order_err, bus.alu_ready, bus.mem_ready);
        end
        @(negedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (bus.WE3 !== 1'b0 || bus.pending !== '0) begin
                fails++; $display("FAIL arst_after%0d: WE3=%b pending=%h want 0/0", i, bus.WE3, bus.pending);
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] awd, mwd;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 59) do_reset();
            awd = $urandom;
            mwd = $urandom;
            drive(($urandom % 3) != 0, int'($urandom_range(0, 7)), awd,
                  ($urandom % 3) != 0, int'($urandom_range(0, 7)), mwd);
            tests++;
            if (bus.alu_ready !== (aq.size() < DEPTH) || bus.mem_ready !== (mq.size() < DEPTH)) begin
                fails++; $display("FAIL rand_ready c%0d: got %b%b want %b%b", c, bus.alu_ready, bus.mem_ready,
                                  aq.size() < DEPTH, mq.size() < DEPTH);
            end
            tests++;
            if (bus.WE3 !== m_we || bus.AD3 !== m_ad || bus.WD3 !== m_wd) begin
                fails++; $display("FAIL rand_port c%0d: got %b/%0d/%h want %b/%0d/%h", c,
                                  bus.WE3, bus.AD3, bus.WD3, m_we, m_ad, m_wd);
            end
            tests++;
            if (bus.pending !== model_pending() || bus.order_err !== m_err) begin
                fails++; $display("FAIL rand_flags c%0d: pending=%h err=%b want %h/%b", c,
                                  bus.pending, bus.order_err, model_pending(), m_err);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        idle();
        test_reset();
        test_single_write();
        test_fill_drain();
        test_x0_filter();
        test_order_err();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
